// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of the DRAM controller user port, with an in-order read tag FIFO.
// Define DRAM_ARB_FIXED_PRIO_EN to make port 0 always win ties instead of round-robin.
module dram_arbiter #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int RD_TAG_DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_p0_rd_en,
  input  logic                      i_p0_wr_en,
  input  logic [APP_ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_p0_data,
  input  logic [APP_MASK_WIDTH-1:0] i_p0_mask,
  output logic                      o_p0_grant,
  output logic [APP_DATA_WIDTH-1:0] o_p0_data,
  output logic                      o_p0_data_valid,
  input  logic                      i_p1_rd_en,
  input  logic                      i_p1_wr_en,
  input  logic [APP_ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_p1_data,
  input  logic [APP_MASK_WIDTH-1:0] i_p1_mask,
  output logic                      o_p1_grant,
  output logic [APP_DATA_WIDTH-1:0] o_p1_data,
  output logic                      o_p1_data_valid,
  output logic                      o_rd_en,
  output logic                      o_wr_en,
  output logic [APP_ADDR_WIDTH-1:0] o_addr,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic [APP_MASK_WIDTH-1:0] o_mask,
  input  logic                      i_ready,
  input  logic                      i_wdf_ready,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic                      i_data_valid,
  input  logic                      i_init_calib_complete,
  output logic                      o_rd_underflow
);

  localparam int PTR_W = $clog2(RD_TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_t;

  state_t                  state;
  logic                    owner;
  logic [RD_TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        tag_count;
  logic                    tag_full;
  logic                    tag_empty;
  logic                    head_tag;
  logic                    elig0;
  logic                    elig1;
  logic                    pick0;
  logic                    pick1;
  logic                    accept;
  logic                    push;
  logic                    pop;
`ifndef DRAM_ARB_FIXED_PRIO_EN
  logic                    last;
`endif

  // Count never exceeds the depth, and depth is a power of two, so the MSB alone flags full.
  assign tag_full  = tag_count[CNT_W-1];
  assign tag_empty = (tag_count == '0);
  assign head_tag  = tag_mem[rd_ptr];

  assign elig0 = i_p0_wr_en | (i_p0_rd_en & ~tag_full);
  assign elig1 = i_p1_wr_en | (i_p1_rd_en & ~tag_full);

`ifdef DRAM_ARB_FIXED_PRIO_EN
  assign pick0 = elig0;
`else
  assign pick0 = elig0 & (~elig1 | last);
`endif
  assign pick1 = elig1 & ~pick0;

  assign o_p0_grant = (state == IDLE) & pick0;
  assign o_p1_grant = (state == IDLE) & pick1;

  assign accept = (state == ISSUE) & i_ready & (o_rd_en | (o_wr_en & i_wdf_ready));
  assign push   = accept & o_rd_en;
  assign pop    = i_data_valid & ~tag_empty;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= WAIT_CAL;
      owner   <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
      o_rd_en <= 1'b0;
      o_wr_en <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      o_mask  <= '0;
    end else begin
      case (state)
        WAIT_CAL: begin
          if (i_init_calib_complete) state <= IDLE;
        end
        IDLE: begin
          // A port asserting both enables is served as a write.
          if (pick0) begin
            owner   <= 1'b0;
            o_wr_en <= i_p0_wr_en;
            o_rd_en <= ~i_p0_wr_en;
            o_addr  <= i_p0_addr;
            o_data  <= i_p0_data;
            o_mask  <= i_p0_mask;
            state   <= ISSUE;
          end else if (pick1) begin
            owner   <= 1'b1;
            o_wr_en <= i_p1_wr_en;
            o_rd_en <= ~i_p1_wr_en;
            o_addr  <= i_p1_addr;
            o_data  <= i_p1_data;
            o_mask  <= i_p1_mask;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            o_rd_en <= 1'b0;
            o_wr_en <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last    <= owner;
`endif
            state   <= IDLE;
          end
        end
        default: state <= WAIT_CAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= owner;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      tag_count <= tag_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Returning data with no outstanding tag has no owner, so it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_p0_data       <= '0;
      o_p1_data       <= '0;
      o_p0_data_valid <= 1'b0;
      o_p1_data_valid <= 1'b0;
      o_rd_underflow  <= 1'b0;
    end else begin
      o_p0_data_valid <= pop & ~head_tag;
      o_p1_data_valid <= pop & head_tag;
      if (pop & ~head_tag) o_p0_data <= i_data;
      if (pop & head_tag)  o_p1_data <= i_data;
      if (i_data_valid & tag_empty) o_rd_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter, checked every cycle against a transaction-level model with a tag queue.
module tb_dram_arbiter;
  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int MW    = 16;
  localparam int DEPTH = 16;
  localparam int CYCLES = 4000;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_p0_rd_en, i_p0_wr_en, i_p1_rd_en, i_p1_wr_en;
  logic [AW-1:0] i_p0_addr, i_p1_addr;
  logic [DW-1:0] i_p0_data, i_p1_data;
  logic [MW-1:0] i_p0_mask, i_p1_mask;
  logic          o_p0_grant, o_p1_grant;
  logic [DW-1:0] o_p0_data, o_p1_data;
  logic          o_p0_data_valid, o_p1_data_valid;
  logic          o_rd_en, o_wr_en;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic [MW-1:0] o_mask;
  logic          i_ready, i_wdf_ready;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic          i_init_calib_complete;
  logic          o_rd_underflow;

  always #5 clk = ~clk;

  dram_arbiter #(
    .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .RD_TAG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .i_p0_rd_en(i_p0_rd_en), .i_p0_wr_en(i_p0_wr_en), .i_p0_addr(i_p0_addr),
    .i_p0_data(i_p0_data), .i_p0_mask(i_p0_mask), .o_p0_grant(o_p0_grant),
    .o_p0_data(o_p0_data), .o_p0_data_valid(o_p0_data_valid),
    .i_p1_rd_en(i_p1_rd_en), .i_p1_wr_en(i_p1_wr_en), .i_p1_addr(i_p1_addr),
    .i_p1_data(i_p1_data), .i_p1_mask(i_p1_mask), .o_p1_grant(o_p1_grant),
    .o_p1_data(o_p1_data), .o_p1_data_valid(o_p1_data_valid),
    .o_rd_en(o_rd_en), .o_wr_en(o_wr_en), .o_addr(o_addr), .o_data(o_data), .o_mask(o_mask),
    .i_ready(i_ready), .i_wdf_ready(i_wdf_ready), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_init_calib_complete(i_init_calib_complete), .o_rd_underflow(o_rd_underflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: calibrated flag, one pending command, last winner, queue of read owners.
  bit            m_cal, m_busy, m_is_rd, m_owner, m_last, m_uf;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  logic [DW-1:0] m_pdata [2];
  bit            m_pvalid [2];
  int            tag_q [$];
  int            full_hits = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cal = 0; m_busy = 0; m_is_rd = 0; m_owner = 0; m_last = 1; m_uf = 0;
    m_addr = '0; m_data = '0; m_mask = '0;
    m_pdata[0] = '0; m_pdata[1] = '0;
    m_pvalid[0] = 0; m_pvalid[1] = 0;
    tag_q.delete();
  endtask

  // Phases alternate between draining reads quickly and starving returns so the tag queue fills.
  task automatic applyStimulus(input int cyc);
    int dv_pct;
    dv_pct = ((cyc / 400) % 2 == 0) ? 35 : 3;
    i_rst        = (cyc > 30) && ($urandom_range(0, 249) == 0);
    i_p0_rd_en   = ($urandom_range(0, 99) < 55);
    i_p0_wr_en   = ($urandom_range(0, 99) < 30);
    i_p1_rd_en   = ($urandom_range(0, 99) < 55);
    i_p1_wr_en   = ($urandom_range(0, 99) < 30);
    i_p0_addr    = AW'($urandom);
    i_p1_addr    = AW'($urandom);
    i_p0_data    = {$urandom, $urandom, $urandom, $urandom};
    i_p1_data    = {$urandom, $urandom, $urandom, $urandom};
    i_p0_mask    = MW'($urandom);
    i_p1_mask    = MW'($urandom);
    i_ready      = ($urandom_range(0, 99) < 75);
    i_wdf_ready  = ($urandom_range(0, 99) < 75);
    i_data       = {$urandom, $urandom, $urandom, $urandom};
    i_data_valid = ($urandom_range(0, 99) < dv_pct);
    i_init_calib_complete = (cyc < 20) ? 1'b0 : ($urandom_range(0, 9) != 0);
  endtask

  initial begin
    bit e0, e1, g0, g1;
    int h;
    i_rst = 1'b1;
    i_p0_rd_en = 0; i_p0_wr_en = 0; i_p1_rd_en = 0; i_p1_wr_en = 0;
    i_p0_addr = '0; i_p1_addr = '0; i_p0_data = '0; i_p1_data = '0;
    i_p0_mask = '0; i_p1_mask = '0; i_ready = 0; i_wdf_ready = 0;
    i_data = '0; i_data_valid = 0; i_init_calib_complete = 0;
    model_reset();
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      applyStimulus(cyc);
      #1;
      e0 = i_p0_wr_en || (i_p0_rd_en && tag_q.size() < DEPTH);
      e1 = i_p1_wr_en || (i_p1_rd_en && tag_q.size() < DEPTH);
      if (tag_q.size() == DEPTH) full_hits++;
      g0 = 0; g1 = 0;
      if (m_cal && !m_busy) begin
        if (e0 && e1) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
          g0 = 1;
`else
          if (m_last) g0 = 1; else g1 = 1;
`endif
        end else begin
          g0 = e0;
          g1 = e1;
        end
      end

      checkOutput("p0_grant", DW'(o_p0_grant), DW'(g0));
      checkOutput("p1_grant", DW'(o_p1_grant), DW'(g1));
      checkOutput("rd_en", DW'(o_rd_en), DW'(m_busy && m_is_rd));
      checkOutput("wr_en", DW'(o_wr_en), DW'(m_busy && !m_is_rd));
      checkOutput("addr", DW'(o_addr), DW'(m_addr));
      checkOutput("data", o_data, m_data);
      checkOutput("mask", DW'(o_mask), DW'(m_mask));
      checkOutput("p0_valid", DW'(o_p0_data_valid), DW'(m_pvalid[0]));
      checkOutput("p1_valid", DW'(o_p1_data_valid), DW'(m_pvalid[1]));
      checkOutput("p0_data", o_p0_data, m_pdata[0]);
      checkOutput("p1_data", o_p1_data, m_pdata[1]);
      checkOutput("underflow", DW'(o_rd_underflow), DW'(m_uf));

      if (i_rst) begin
        model_reset();
      end else begin
        // Return path uses the queue as it stood before this cycle's accept.
        m_pvalid[0] = 0; m_pvalid[1] = 0;
        if (i_data_valid) begin
          if (tag_q.size() > 0) begin
            h = tag_q.pop_front();
            m_pdata[h] = i_data;
            m_pvalid[h] = 1;
          end else begin
            m_uf = 1;
          end
        end
        if (!m_cal) begin
          if (i_init_calib_complete) m_cal = 1;
        end else if (!m_busy) begin
          if (g0) begin
            m_owner = 0; m_is_rd = !i_p0_wr_en;
            m_addr = i_p0_addr; m_data = i_p0_data; m_mask = i_p0_mask; m_busy = 1;
          end else if (g1) begin
            m_owner = 1; m_is_rd = !i_p1_wr_en;
            m_addr = i_p1_addr; m_data = i_p1_data; m_mask = i_p1_mask; m_busy = 1;
          end
        end else if (i_ready && (m_is_rd || i_wdf_ready)) begin
          if (m_is_rd) tag_q.push_back(int'(m_owner));
          m_last = m_owner;
          m_busy = 0;
        end
      end
    end

    $display("[TB] cycles with tag queue full: %0d", full_hits);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-requester arbiter that shares the single DRAM_CONTROLLER user port (rd_en/wr_en/addr/data/mask, ready/wdf_ready, read data return) between two PL clients. It sits between the clients and DRAM_CONTROLLER in the `ui_clk` domain and holds every client off until calibration completes. It grants one command at a time, round-robin, and holds the command until DRAM_CONTROLLER accepts it. Reads return in issue order, so the arbiter records the owning port of each issued read in a tag FIFO and steers returning read data to that port.

## Interface
- APP_ADDR_WIDTH, 28, command address width
- APP_DATA_WIDTH, 128, data width
- APP_MASK_WIDTH, 16, write byte-mask width
- RD_TAG_DEPTH, 16, maximum outstanding reads (power of 2, ≥2)

Ports:
- clk  in  1  ui clock (`o_clk` of DRAM_CONTROLLER); single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_pN_rd_en / i_pN_wr_en  in  1 each  read/write request, N=0,1; level, held until grant
- i_pN_addr  in  APP_ADDR_WIDTH  request address
- i_pN_data  in  APP_DATA_WIDTH  write data
- i_pN_mask  in  APP_MASK_WIDTH  write mask
- o_pN_grant  out  1  one-cycle pulse: request captured
- o_pN_data  out  APP_DATA_WIDTH  read data to port N
- o_pN_data_valid  out  1  read data valid for port N
- o_rd_en / o_wr_en  out  1  command to DRAM_CONTROLLER
- o_addr, o_data, o_mask  out  APP_ADDR/DATA/MASK_WIDTH  command fields
- i_ready, i_wdf_ready  in  1  DRAM_CONTROLLER command and write-data ready
- i_data  in  APP_DATA_WIDTH  read data from DRAM_CONTROLLER
- i_data_valid  in  1  read data valid
- i_init_calib_complete  in  1  calibration done
- o_rd_underflow  out  1  sticky: i_data_valid arrived while the tag FIFO was empty

## Operation
- FSM states:
  - WAIT_CAL: exits to IDLE on the first cycle `i_init_calib_complete`=1. Later deassertion of calibration is ignored.
  - IDLE: chooses a winner among eligible ports.
    - A port is eligible if `wr_en`=1, or if `rd_en`=1 and the tag count < RD_TAG_DEPTH.
    - If both `rd_en` and `wr_en` are 1 on one port, the request is treated as a write.
    - On a win: latch addr, data, mask and op into the output registers; pulse `o_pN_grant`; store `owner`=N; go to ISSUE.
  - ISSUE: `o_rd_en` or `o_wr_en` is high with stable fields.
    - A read is accepted when `i_ready`=1. A write is accepted when `i_ready`=1 and `i_wdf_ready`=1.
    - On accept: drop the enable; for a read, push `owner` into the tag FIFO; update `last`=`owner`; go to IDLE.
- Round-robin:
  - If only one port is eligible, it wins.
  - If both are eligible, the port ≠ `last` wins.
- Tag FIFO (RD_TAG_DEPTH × 1 bit, wrapping pointers, count 0..RD_TAG_DEPTH):
  - A push and a pop in the same cycle leave the count unchanged.
  - Full blocks reads only; writes still win.
- Read return:
  - Each `i_data_valid` pops the head entry.
  - `i_data` is registered onto `o_pH_data` and `o_pH_data_valid` is pulsed, where H is the popped tag.
  - The other port's valid stays 0.
  - If `i_data_valid` arrives while the FIFO is empty: the data is dropped, no valid is asserted, and `o_rd_underflow` is set to 1 until reset.
- Reset values:
  - FSM=WAIT_CAL, `last`=1 (port 0 wins the first tie), FIFO empty.
  - All outputs 0, including data buses and `o_rd_underflow`.
- Reset mid-operation: any command in flight and all outstanding tags are discarded. Read data returning after reset sets `o_rd_underflow`.

## Timing
- A request seen in IDLE at cycle T gives `o_pN_grant`=1 at T (combinational from the IDLE decision) and the command on `o_rd_en`/`o_wr_en` from T+1.
- The requester may change or drop its request from T+1.
- Command throughput is at most one per 2 cycles (IDLE, ISSUE).
- Read data latency through the arbiter: `o_pN_data_valid` at T+1 for `i_data_valid` at T. Back-to-back valids are supported every cycle.
- A tag push at the accept cycle and a pop in that same cycle are legal: a read returning the cycle after accept is routed correctly.

## Configuration
- `DRAM_ARB_FIXED_PRIO_EN` defined: fixed priority; port 0 always wins when both ports are eligible, and `last` is unused.
- `DRAM_ARB_FIXED_PRIO_EN` undefined: round-robin as described under Operation.

## Test plan
- Calibration gate: requests on both ports with `i_init_calib_complete`=0 for 20 cycles → no grant and `o_rd_en`=`o_wr_en`=0; raise calibration → `o_p0_grant` the next cycle.
- Round-robin: both ports request writes continuously with `i_ready`=`i_wdf_ready`=1 → grants alternate p0, p1, p0, p1; `o_addr` matches the granted port.
- Backpressure: p1 read, `i_ready`=0 for 5 cycles → `o_rd_en` and `o_addr` held stable for 5 cycles; accept on the 6th; exactly one tag pushed.
- Routing: reads issued in order p0 A, p1 B, p0 C; return data D1, D2, D3 → D1 on p0, D2 on p1, D3 on p0, each one cycle after `i_data_valid`.
- Tag full: RD_TAG_DEPTH reads outstanding, p0 read and p1 write pending → only p1 granted; one `i_data_valid` then allows the p0 read.
- Underflow and reset: `i_data_valid` with an empty FIFO → no port valid, `o_rd_underflow`=1; `i_rst` mid-ISSUE → all outputs 0 the next cycle and FSM in WAIT_CAL.
